// File: rtl/rtc_pkg.sv
// Shared constants, time record type and 12h display conversion for the RTC core.
package rtc_pkg;

    localparam int unsigned SEC_MAX = 59;
    localparam int unsigned MIN_MAX = 59;
    localparam int unsigned HOUR_W  = 5;
    localparam int unsigned MS_W    = 6;

    typedef struct packed {
        logic [HOUR_W-1:0] hour;
        logic [MS_W-1:0]   minute;
        logic [MS_W-1:0]   second;
    } rtc_time_t;

    // Midnight shows as 12, afternoon hours fold down by 12.
    function automatic logic [HOUR_W-1:0] to_12h(input logic [HOUR_W-1:0] hour);
        if (hour == '0) begin
            return HOUR_W'(12);
        end else if (hour > HOUR_W'(12)) begin
            return hour - HOUR_W'(12);
        end else begin
            return hour;
        end
    endfunction

endpackage

// File: rtl/rtc_prescaler.sv
// Free-running divider that strobes term on the last count of each PRESCALE-cycle period.
module rtc_prescaler #(
    parameter int unsigned PRESCALE = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic clear,
    output logic term
);

    localparam int unsigned CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);

    logic [CNT_W-1:0] cnt;

    // Strobe is combinational so the time advances on the same edge the count wraps.
    assign term = run && (cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (run) begin
            if (term) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/rtc_core.sv
// HH:MM:SS real-time-clock core with runtime set, run/pause and 12h/24h display.
// Optional alarm comparator is built when RTC_ALARM_EN is defined.
module rtc_core
    import rtc_pkg::*;
#(
    parameter int unsigned PRESCALE  = 50_000_000,
    parameter int unsigned HOURS_DAY = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic              mode_12h,
    input  logic              set_valid,
    input  logic [HOUR_W-1:0] set_hour,
    input  logic [MS_W-1:0]   set_min,
    input  logic [MS_W-1:0]   set_sec,
    output logic              set_err,
    output logic [MS_W-1:0]   second,
    output logic [MS_W-1:0]   minute,
    output logic [HOUR_W-1:0] hour,
    output logic [HOUR_W-1:0] hour_disp,
    output logic              pm,
    output logic              tick_sec,
    output logic              tick_min,
    output logic              tick_day
`ifdef RTC_ALARM_EN
    ,
    input  logic              alarm_arm,
    input  logic [HOUR_W-1:0] alarm_hour,
    input  logic [MS_W-1:0]   alarm_min,
    output logic              alarm_hit
`endif
);

    localparam logic [HOUR_W-1:0] HOUR_LAST = HOUR_W'(HOURS_DAY - 1);
    localparam logic [MS_W-1:0]   SEC_LAST  = MS_W'(SEC_MAX);
    localparam logic [MS_W-1:0]   MIN_LAST  = MS_W'(MIN_MAX);

    rtc_time_t time_q;
    rtc_time_t time_adv;
    logic      term;
    logic      set_ok;
    logic      load;
    logic      advance;
    logic      sec_wrap;
    logic      min_wrap;
    logic      day_wrap;

    assign set_ok  = (set_hour <= HOUR_LAST) && (set_min <= MIN_LAST) && (set_sec <= SEC_LAST);
    assign load    = set_valid && set_ok;
    // A valid set swallows a coincident terminal count.
    assign advance = term && !load;

    rtc_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk   (clk),
        .rst   (rst),
        .run   (run),
        .clear (load),
        .term  (term)
    );

    // Whole carry chain resolved in one cycle.
    always_comb begin
        time_adv = time_q;
        sec_wrap = (time_q.second == SEC_LAST);
        min_wrap = sec_wrap && (time_q.minute == MIN_LAST);
        day_wrap = min_wrap && (time_q.hour == HOUR_LAST);
        if (sec_wrap) begin
            time_adv.second = '0;
            if (min_wrap) begin
                time_adv.minute = '0;
                time_adv.hour   = day_wrap ? '0 : time_q.hour + HOUR_W'(1);
            end else begin
                time_adv.minute = time_q.minute + MS_W'(1);
            end
        end else begin
            time_adv.second = time_q.second + MS_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            time_q   <= '0;
            set_err  <= 1'b0;
            tick_sec <= 1'b0;
            tick_min <= 1'b0;
            tick_day <= 1'b0;
        end else begin
            set_err  <= set_valid && !set_ok;
            tick_sec <= advance;
            tick_min <= advance && sec_wrap;
            tick_day <= advance && day_wrap;
            if (load) begin
                time_q <= '{hour: set_hour, minute: set_min, second: set_sec};
            end else if (term) begin
                time_q <= time_adv;
            end
        end
    end

`ifdef RTC_ALARM_EN
    // Only a tick advance can land on the alarm time; a set never fires it.
    always_ff @(posedge clk) begin
        if (rst) begin
            alarm_hit <= 1'b0;
        end else begin
            alarm_hit <= alarm_arm && advance
                         && (time_adv.hour == alarm_hour)
                         && (time_adv.minute == alarm_min)
                         && (time_adv.second == '0);
        end
    end
`endif

    assign second    = time_q.second;
    assign minute    = time_q.minute;
    assign hour      = time_q.hour;
    assign hour_disp = mode_12h ? to_12h(time_q.hour) : time_q.hour;
    assign pm        = (time_q.hour >= HOUR_W'(12));

endmodule

// File: tb/tb_rtc_core.sv
// Directed scoreboard bench for rtc_core with PRESCALE=4; alarm steps build with RTC_ALARM_EN.
module tb_rtc_core;

    logic       clk;
    logic       rst;
    logic       run;
    logic       mode_12h;
    logic       set_valid;
    logic [4:0] set_hour;
    logic [5:0] set_min;
    logic [5:0] set_sec;
    logic       set_err;
    logic [5:0] second;
    logic [5:0] minute;
    logic [4:0] hour;
    logic [4:0] hour_disp;
    logic       pm;
    logic       tick_sec;
    logic       tick_min;
    logic       tick_day;
`ifdef RTC_ALARM_EN
    logic       alarm_arm;
    logic [4:0] alarm_hour;
    logic [5:0] alarm_min;
    logic       alarm_hit;
`endif

    rtc_core #(
        .PRESCALE  (4),
        .HOURS_DAY (24)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .mode_12h  (mode_12h),
        .set_valid (set_valid),
        .set_hour  (set_hour),
        .set_min   (set_min),
        .set_sec   (set_sec),
        .set_err   (set_err),
        .second    (second),
        .minute    (minute),
        .hour      (hour),
        .hour_disp (hour_disp),
        .pm        (pm),
        .tick_sec  (tick_sec),
        .tick_min  (tick_min),
        .tick_day  (tick_day)
`ifdef RTC_ALARM_EN
        ,
        .alarm_arm  (alarm_arm),
        .alarm_hour (alarm_hour),
        .alarm_min  (alarm_min),
        .alarm_hit  (alarm_hit)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0] hour;
        logic [5:0] min;
        logic [5:0] sec;
        logic [4:0] hdisp;
        logic       pm;
        logic       ts;
        logic       tm;
        logic       td;
        logic       err;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic push(input int h, input int m, input int s, input int hd, input logic p,
                        input logic ts, input logic tm, input logic td, input logic err);
        exp_t e;
        e.hour  = 5'(h);
        e.min   = 6'(m);
        e.sec   = 6'(s);
        e.hdisp = 5'(hd);
        e.pm    = p;
        e.ts    = ts;
        e.tm    = tm;
        e.td    = td;
        e.err   = err;
        sb.push_back(e);
    endtask

    task automatic check(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            chk({tag, ".sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk({tag, ".hour"},      32'(hour),      32'(e.hour));
            chk({tag, ".minute"},    32'(minute),    32'(e.min));
            chk({tag, ".second"},    32'(second),    32'(e.sec));
            chk({tag, ".hour_disp"}, 32'(hour_disp), 32'(e.hdisp));
            chk({tag, ".pm"},        32'(pm),        32'(e.pm));
            chk({tag, ".tick_sec"},  32'(tick_sec),  32'(e.ts));
            chk({tag, ".tick_min"},  32'(tick_min),  32'(e.tm));
            chk({tag, ".tick_day"},  32'(tick_day),  32'(e.td));
            chk({tag, ".set_err"},   32'(set_err),   32'(e.err));
        end
    endtask

    task automatic do_set(input int h, input int m, input int s);
        set_valid = 1'b1;
        set_hour  = 5'(h);
        set_min   = 6'(m);
        set_sec   = 6'(s);
    endtask

    initial begin
        rst       = 1'b1;
        run       = 1'b1;
        mode_12h  = 1'b0;
        set_valid = 1'b0;
        set_hour  = '0;
        set_min   = '0;
        set_sec   = '0;
`ifdef RTC_ALARM_EN
        alarm_arm  = 1'b0;
        alarm_hour = '0;
        alarm_min  = '0;
`endif

        // Reset and first tick latency
        tick(3);
        push(0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("reset");
        mode_12h = 1'b1;
        #1;
        push(0, 0, 0, 12, 0, 0, 0, 0, 0);
        check("reset_12h");
        mode_12h = 1'b0;
        rst = 1'b0;
        push(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick(3);
        check("pre_first_tick");
        push(0, 0, 1, 0, 0, 1, 0, 0, 0);
        tick(1);
        check("first_tick");
        push(0, 0, 1, 0, 0, 0, 0, 0, 0);
        tick(1);
        check("tick_sec_one_cycle");

        // Day wrap
        do_set(23, 59, 58);
        push(23, 59, 58, 23, 1, 0, 0, 0, 0);
        tick(1);
        check("set_235958");
        set_valid = 1'b0;
        push(23, 59, 59, 23, 1, 1, 0, 0, 0);
        tick(4);
        check("to_235959");
        push(0, 0, 0, 0, 0, 1, 1, 1, 0);
        tick(4);
        check("day_wrap");

        // Invalid set, then set coincident with terminal count
        do_set(5, 60, 5);
        push(0, 0, 0, 0, 0, 0, 0, 0, 1);
        tick(1);
        check("bad_min60");
        set_valid = 1'b0;
        push(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick(1);
        check("err_one_cycle");
        tick(1);
        do_set(1, 2, 3);
        push(1, 2, 3, 1, 0, 0, 0, 0, 0);
        tick(1);
        check("set_beats_term");
        set_valid = 1'b0;
        push(1, 2, 3, 1, 0, 0, 0, 0, 0);
        tick(1);
        check("after_set_term");
        tick(2);
        do_set(24, 0, 0);
        push(1, 2, 4, 1, 0, 1, 0, 0, 1);
        tick(1);
        check("bad_hour_with_term");
        set_valid = 1'b0;

        // 12h display
        mode_12h = 1'b1;
        do_set(13, 0, 0);
        push(13, 0, 0, 1, 1, 0, 0, 0, 0);
        tick(1);
        check("disp_13");
        do_set(12, 0, 0);
        push(12, 0, 0, 12, 1, 0, 0, 0, 0);
        tick(1);
        check("disp_12");
        do_set(0, 30, 0);
        push(0, 30, 0, 12, 0, 0, 0, 0, 0);
        tick(1);
        check("disp_00");
        set_valid = 1'b0;
        mode_12h = 1'b0;
        #1;
        push(0, 30, 0, 0, 0, 0, 0, 0, 0);
        check("disp_24h_00");

        // Pause mid-count
        tick(2);
        run = 1'b0;
        for (int i = 0; i < 10; i++) begin
            push(0, 30, 0, 0, 0, 0, 0, 0, 0);
            tick(1);
            check("paused");
        end
        run = 1'b1;
        push(0, 30, 0, 0, 0, 0, 0, 0, 0);
        tick(1);
        check("resume_no_tick");
        push(0, 30, 1, 0, 0, 1, 0, 0, 0);
        tick(1);
        check("resume_tick");

        // Reset mid-count clears prescaler too
        tick(1);
        rst = 1'b1;
        push(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick(1);
        check("mid_reset");
        rst = 1'b0;
        push(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick(3);
        check("post_reset_no_tick");
        push(0, 0, 1, 0, 0, 1, 0, 0, 0);
        tick(1);
        check("post_reset_tick");

`ifdef RTC_ALARM_EN
        alarm_arm  = 1'b1;
        alarm_hour = 5'd7;
        alarm_min  = 6'd15;
        do_set(7, 14, 58);
        tick(1);
        chk("alarm_on_set_a", 32'(alarm_hit), 32'd0);
        set_valid = 1'b0;
        tick(4);
        chk("alarm_at_145", 32'(alarm_hit), 32'd0);
        push(7, 15, 0, 7, 0, 1, 1, 0, 0);
        tick(4);
        check("alarm_time");
        chk("alarm_hit", 32'(alarm_hit), 32'd1);
        tick(1);
        chk("alarm_one_cycle", 32'(alarm_hit), 32'd0);
        do_set(7, 15, 0);
        tick(1);
        chk("alarm_set_direct", 32'(alarm_hit), 32'd0);
        set_valid = 1'b0;
        tick(1);
        chk("alarm_after_set", 32'(alarm_hit), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
